// File: rtl/laplacian_window_gen_if.sv
// Stream bundle for the Laplacian window generator.
// Corner taps exist only when LAP_WIN_CORNERS_EN is defined.
interface laplacian_window_gen_if #(
  parameter int PW = 8
);
  logic          s_valid;
  logic          s_ready;
  logic          s_sof;
  logic [PW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;
  logic [PW-1:0] m_top;
  logic [PW-1:0] m_left;
  logic [PW-1:0] m_center;
  logic [PW-1:0] m_right;
  logic [PW-1:0] m_bottom;
`ifdef LAP_WIN_CORNERS_EN
  logic [PW-1:0] m_tl;
  logic [PW-1:0] m_tr;
  logic [PW-1:0] m_bl;
  logic [PW-1:0] m_br;

  modport master (
    output s_valid, s_sof, s_data, m_ready,
    input  s_ready, m_valid, m_last,
    input  m_top, m_left, m_center, m_right, m_bottom,
    input  m_tl, m_tr, m_bl, m_br
  );

  modport slave (
    input  s_valid, s_sof, s_data, m_ready,
    output s_ready, m_valid, m_last,
    output m_top, m_left, m_center, m_right, m_bottom,
    output m_tl, m_tr, m_bl, m_br
  );
`else
  modport master (
    output s_valid, s_sof, s_data, m_ready,
    input  s_ready, m_valid, m_last,
    input  m_top, m_left, m_center, m_right, m_bottom
  );

  modport slave (
    input  s_valid, s_sof, s_data, m_ready,
    output s_ready, m_valid, m_last,
    output m_top, m_left, m_center, m_right, m_bottom
  );
`endif
endinterface

// File: rtl/laplacian_window_gen.sv
// Streaming 3x3 cross-window generator with two line buffers.
// Optional corner taps: define LAP_WIN_CORNERS_EN.
module laplacian_window_gen #(
  parameter int ROWS = 242,
  parameter int COLS = 247,
  parameter int PW   = 8
) (
  input  logic clk,
  input  logic rst_n,
  laplacian_window_gen_if.slave bus
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic [PW-1:0] r_line0 [COLS];
  logic [PW-1:0] r_line1 [COLS];

  // Column c-1 (all three rows) and column c-2 of the live window.
  logic [PW-1:0] r_c0_t;
  logic [PW-1:0] r_c0_m;
  logic [PW-1:0] r_c0_b;
  logic [PW-1:0] r_c1_m;
`ifdef LAP_WIN_CORNERS_EN
  logic [PW-1:0] r_c1_t;
  logic [PW-1:0] r_c1_b;
  logic [PW-1:0] r_tl;
  logic [PW-1:0] r_tr;
  logic [PW-1:0] r_bl;
  logic [PW-1:0] r_br;
`endif

  logic          r_m_valid;
  logic          r_m_last;
  logic [PW-1:0] r_top;
  logic [PW-1:0] r_left;
  logic [PW-1:0] r_center;
  logic [PW-1:0] r_right;
  logic [PW-1:0] r_bottom;

  logic          w_acc;
  logic          w_win;
  logic          w_last;
  logic          w_col_end;
  logic          w_row_end;
  logic [RW-1:0] w_row;
  logic [CW-1:0] w_col;
  logic [PW-1:0] w_l0;
  logic [PW-1:0] w_l1;

  assign bus.s_ready = !r_m_valid || bus.m_ready;
  assign w_acc       = bus.s_valid && bus.s_ready;

  // A start-of-frame beat is pixel (0,0) whatever the counters say.
  always_comb begin
    w_row = r_row;
    w_col = r_col;
    if (bus.s_sof) begin
      w_row = '0;
      w_col = '0;
    end
  end

  assign w_col_end = (w_col == CW'(COLS - 1));
  assign w_row_end = (w_row == RW'(ROWS - 1));
  assign w_last    = w_col_end && w_row_end;
  assign w_win     = w_acc && (w_row >= RW'(2)) && (w_col >= CW'(2));
  assign w_l0      = r_line0[w_col];
  assign w_l1      = r_line1[w_col];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_acc) begin
      if (w_col_end) begin
        r_col <= '0;
        r_row <= w_row_end ? '0 : w_row + RW'(1);
      end else begin
        r_col <= w_col + CW'(1);
        r_row <= w_row;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_line1[w_col] <= r_line0[w_col];
      r_line0[w_col] <= bus.s_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c0_t <= '0;
      r_c0_m <= '0;
      r_c0_b <= '0;
      r_c1_m <= '0;
`ifdef LAP_WIN_CORNERS_EN
      r_c1_t <= '0;
      r_c1_b <= '0;
`endif
    end else if (w_acc) begin
      r_c0_t <= w_l1;
      r_c0_m <= w_l0;
      r_c0_b <= bus.s_data;
      r_c1_m <= r_c0_m;
`ifdef LAP_WIN_CORNERS_EN
      r_c1_t <= r_c0_t;
      r_c1_b <= r_c0_b;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
      r_top     <= '0;
      r_left    <= '0;
      r_center  <= '0;
      r_right   <= '0;
      r_bottom  <= '0;
`ifdef LAP_WIN_CORNERS_EN
      r_tl      <= '0;
      r_tr      <= '0;
      r_bl      <= '0;
      r_br      <= '0;
`endif
    end else if (w_win) begin
      r_m_valid <= 1'b1;
      r_m_last  <= w_last;
      r_top     <= r_c0_t;
      r_left    <= r_c1_m;
      r_center  <= r_c0_m;
      r_right   <= w_l0;
      r_bottom  <= r_c0_b;
`ifdef LAP_WIN_CORNERS_EN
      r_tl      <= r_c1_t;
      r_tr      <= w_l1;
      r_bl      <= r_c1_b;
      r_br      <= bus.s_data;
`endif
    end else if (bus.m_ready) begin
      r_m_valid <= 1'b0;
    end
  end

  assign bus.m_valid  = r_m_valid;
  assign bus.m_last   = r_m_last;
  assign bus.m_top    = r_top;
  assign bus.m_left   = r_left;
  assign bus.m_center = r_center;
  assign bus.m_right  = r_right;
  assign bus.m_bottom = r_bottom;
`ifdef LAP_WIN_CORNERS_EN
  assign bus.m_tl     = r_tl;
  assign bus.m_tr     = r_tr;
  assign bus.m_bl     = r_bl;
  assign bus.m_br     = r_br;
`endif

endmodule

// File: tb/tb_laplacian_window_gen.sv
// Directed bench for laplacian_window_gen on a 4x5 ramp image.
// Corner taps are checked when LAP_WIN_CORNERS_EN is defined.
module tb_laplacian_window_gen;

  localparam int ROWS = 4;
  localparam int COLS = 5;
  localparam int NPIX = ROWS * COLS;

  typedef struct packed {
    logic [7:0] t;
    logic [7:0] l;
    logic [7:0] c;
    logic [7:0] r;
    logic [7:0] b;
    logic       last;
    logic [7:0] tl;
    logic [7:0] tr;
    logic [7:0] bl;
    logic [7:0] br;
  } win_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_fail;
  win_t exp_win [6];
  win_t got [$];

  laplacian_window_gen_if #(.PW(8)) bus ();

  laplacian_window_gen #(
    .ROWS(ROWS),
    .COLS(COLS),
    .PW  (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    win_t w;
    if (rst_n && bus.m_valid && bus.m_ready) begin
      w.t    = bus.m_top;
      w.l    = bus.m_left;
      w.c    = bus.m_center;
      w.r    = bus.m_right;
      w.b    = bus.m_bottom;
      w.last = bus.m_last;
`ifdef LAP_WIN_CORNERS_EN
      w.tl   = bus.m_tl;
      w.tr   = bus.m_tr;
      w.bl   = bus.m_bl;
      w.br   = bus.m_br;
`else
      w.tl   = '0;
      w.tr   = '0;
      w.bl   = '0;
      w.br   = '0;
`endif
      got.push_back(w);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    bus.s_valid = 1'b0;
    bus.s_sof   = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b1;
    rst_n       = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic sof);
    bit ok;
    ok = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_sof   = sof;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      ok = bus.s_ready;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
    bus.s_valid = 1'b0;
    bus.s_sof   = 1'b0;
  endtask

  // Ramp pixels base+10r+c for linear indices lo..hi, m_ready held high.
  task automatic send_range(input int base, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      int r;
      int c;
      r = i / COLS;
      c = i % COLS;
      send(8'(base + 10 * r + c), i == 0);
      chk($sformatf("m_valid_after_px%0d", i), bus.m_valid,
          (r >= 2 && c >= 2) ? 1 : 0);
      if (i == 12) chk("first_center", bus.m_center, base + 11);
      if (i == NPIX - 1) chk("m_last_at_end", bus.m_last, 1);
    end
  endtask

  task automatic drain();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input int base, input int idx0);
    for (int i = 0; i < 6; i++) begin
      win_t w;
      win_t e;
      e = exp_win[i];
      if (idx0 + i >= got.size()) begin
        chk($sformatf("win%0d_missing", idx0 + i), 32'd0, 32'd1);
      end else begin
        w = got[idx0 + i];
        chk($sformatf("win%0d_top", idx0 + i), w.t, e.t + base);
        chk($sformatf("win%0d_left", idx0 + i), w.l, e.l + base);
        chk($sformatf("win%0d_center", idx0 + i), w.c, e.c + base);
        chk($sformatf("win%0d_right", idx0 + i), w.r, e.r + base);
        chk($sformatf("win%0d_bottom", idx0 + i), w.b, e.b + base);
        chk($sformatf("win%0d_last", idx0 + i), w.last, e.last);
`ifdef LAP_WIN_CORNERS_EN
        chk($sformatf("win%0d_tl", idx0 + i), w.tl, e.tl + base);
        chk($sformatf("win%0d_tr", idx0 + i), w.tr, e.tr + base);
        chk($sformatf("win%0d_bl", idx0 + i), w.bl, e.bl + base);
        chk($sformatf("win%0d_br", idx0 + i), w.br, e.br + base);
`endif
      end
    end
  endtask

  initial begin
    int nlast;
    n_vec  = 0;
    n_fail = 0;
    //            t    l    c    r    b  last  tl   tr   bl   br
    exp_win[0] = '{8'd1, 8'd10, 8'd11, 8'd12, 8'd21, 1'b0,
                   8'd0, 8'd2, 8'd20, 8'd22};
    exp_win[1] = '{8'd2, 8'd11, 8'd12, 8'd13, 8'd22, 1'b0,
                   8'd1, 8'd3, 8'd21, 8'd23};
    exp_win[2] = '{8'd3, 8'd12, 8'd13, 8'd14, 8'd23, 1'b0,
                   8'd2, 8'd4, 8'd22, 8'd24};
    exp_win[3] = '{8'd11, 8'd20, 8'd21, 8'd22, 8'd31, 1'b0,
                   8'd10, 8'd12, 8'd30, 8'd32};
    exp_win[4] = '{8'd12, 8'd21, 8'd22, 8'd23, 8'd32, 1'b0,
                   8'd11, 8'd13, 8'd31, 8'd33};
    exp_win[5] = '{8'd13, 8'd22, 8'd23, 8'd24, 8'd33, 1'b1,
                   8'd12, 8'd14, 8'd32, 8'd34};

    // Reset state
    do_reset();
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_last", bus.m_last, 0);
    chk("rst_center", bus.m_center, 0);
    chk("rst_top", bus.m_top, 0);
    chk("rst_bottom", bus.m_bottom, 0);
    chk("rst_s_ready", bus.s_ready, 1);

    // Single frame, free-running sink
    got.delete();
    send_range(0, 0, NPIX - 1);
    drain();
    chk("frame1_count", got.size(), 6);
    check_frame(0, 0);

    // Sink stalls five cycles on the first window
    do_reset();
    got.delete();
    send_range(0, 0, 12);
    bus.m_ready = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = 8'd23;
    repeat (5) begin
      @(negedge clk);
      chk("stall_s_ready", bus.s_ready, 0);
      chk("stall_m_valid", bus.m_valid, 1);
      chk("stall_top", bus.m_top, 1);
      chk("stall_left", bus.m_left, 10);
      chk("stall_center", bus.m_center, 11);
      chk("stall_right", bus.m_right, 12);
      chk("stall_bottom", bus.m_bottom, 21);
    end
    @(posedge clk);
    #1;
    bus.m_ready = 1'b1;
    send(8'd23, 1'b0);
    send_range(0, 14, NPIX - 1);
    drain();
    chk("stall_count", got.size(), 6);
    check_frame(0, 0);

    // Two frames back to back
    do_reset();
    got.delete();
    send_range(0, 0, NPIX - 1);
    send_range(100, 0, NPIX - 1);
    drain();
    chk("b2b_count", got.size(), 12);
    check_frame(0, 0);
    check_frame(100, 6);
    nlast = 0;
    foreach (got[i]) if (got[i].last) nlast++;
    chk("b2b_last_count", nlast, 2);

    // Start-of-frame arriving at (1,3)
    do_reset();
    got.delete();
    send_range(0, 0, 7);
    send(8'd0, 1'b1);
    chk("sof_no_window", bus.m_valid, 0);
    send_range(0, 1, NPIX - 1);
    drain();
    chk("sof_count", got.size(), 6);
    check_frame(0, 0);

    // Reset while a window is held
    do_reset();
    got.delete();
    send_range(0, 0, 13);
    chk("pre_rst_center", bus.m_center, 12);
    chk("pre_rst_valid", bus.m_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus.m_valid, 0);
    chk("mid_rst_center", bus.m_center, 0);
    chk("mid_rst_s_ready", bus.s_ready, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    got.delete();
    send_range(0, 0, NPIX - 1);
    drain();
    chk("post_rst_count", got.size(), 6);
    check_frame(0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/laplacian_window_gen.md
# laplacian_window_gen

Streaming 3x3 neighbourhood generator that sits directly upstream of the Laplacian filter stage. Accepts an 8-bit greyscale image in raster order, one pixel per handshake. Buffers two lines and emits, for every interior pixel, the four-neighbour cross (top/left/centre/right/bottom) that the filter's kernel consumes. Border pixels produce no output; the downstream filter writes 0 there itself.

## Interface
- `ROWS`, 242, image height in pixels (>= 3)
- `COLS`, 247, image width in pixels (>= 3)
- `PW`, 8, pixel width in bits
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `s_valid`  in  1  input pixel valid
- `s_ready`  out  1  input can be accepted
- `s_data`  in  PW  input pixel, raster order
- `s_sof`  in  1  start of frame; qualifies the current `s_data` beat
- `m_valid`  out  1  output window valid
- `m_ready`  in  1  downstream accepts window
- `m_top`, `m_left`, `m_center`, `m_right`, `m_bottom`  out  PW each  cross taps around the centre pixel
- `m_last`  out  1  window is the last interior window of the frame
- `m_tl`, `m_tr`, `m_bl`, `m_br`  out  PW each  corner taps; present only with `LAP_WIN_CORNERS_EN`

## Operation
- Input transfer occurs when `s_valid && s_ready`. Output transfer occurs when `m_valid && m_ready`.
- Column counter `col` runs 0..COLS-1. Row counter `row` runs 0..ROWS-1. Both address the pixel being accepted.
- After (ROWS-1, COLS-1) is accepted, both counters wrap to (0,0).
- An accepted beat with `s_sof=1` is treated as pixel (0,0) regardless of counter state; counters continue from (0,1).
- Line storage:
  - Two line buffers of COLS x PW, indexed by `col`.
  - On every accepted pixel, line0[col] moves to line1[col] and `s_data` is written to line0[col].
  - Line buffer contents are not reset.
- Column shift registers:
  - Each holds 3 columns of 3 rows, shifting on every accepted pixel.
  - New column = {line1[col], line0[col], s_data}.
- Window emission:
  - An accepted pixel at (r,c) with r>=2 and c>=2 loads the output register with the window centred at (r-1, c-1).
  - Taps: top = (r-2, c-1), left = (r-1, c-2), center = (r-1, c-1), right = (r-1, c), bottom = (r, c-1).
  - `m_last`=1 iff r=ROWS-1 and c=COLS-1.
- Accepted pixels with r<2 or c<2 update the buffers and emit nothing.
- Windows per frame = (ROWS-2)*(COLS-2).
- No arithmetic is done on pixel values; taps are raw copies.

## Timing
- `s_ready = !m_valid || m_ready`, combinational. Input stalls only while a window is held unconsumed.
- Latency: the window triggered by the pixel accepted at edge N is on `m_*` with `m_valid`=1 after edge N.
- `m_valid` clears after an output transfer, unless the same edge loads a new window.
- While `m_valid && !m_ready`, all `m_*` outputs hold stable and no input is accepted.
- Throughput: one pixel per cycle; one window per cycle sustained in the interior.
- Back-to-back frames: pixel (0,0) of frame N+1 may be accepted the cycle after (ROWS-1, COLS-1) of frame N.
- Reset values (asynchronous assert, synchronous deassert by the system):
  - `m_valid`=0, `m_last`=0, all tap outputs 0
  - `row`=0, `col`=0, shift registers 0
  - `s_ready`=1 immediately after reset
- Reset mid-frame discards the held window and restarts at (0,0). The first two rows after reset emit nothing, so stale line-buffer data is never output.
- `s_sof` mid-frame behaves the same as reset for the counters, but does not clear a held output window; that window still completes its handshake.

## Configuration
- `LAP_WIN_CORNERS_EN` defined:
  - Extra shift taps and ports `m_tl`=(r-2, c-2), `m_tr`=(r-2, c), `m_bl`=(r, c-2), `m_br`=(r, c) are present, registered with the cross taps.
  - Supports the 8-neighbour kernel.
- Undefined: corner ports and their registers do not exist; behaviour is otherwise identical.

## Test plan
- ROWS=4, COLS=5, pixel = 10*r+c, `m_ready`=1 → 6 windows. First: center 11, top 1, left 10, right 12, bottom 21, one cycle after accepting (2,2). Last: center 23, `m_last`=1.
- Same frame, `m_ready` low for 5 cycles at the first window → `s_ready`=0, taps hold 1/10/11/12/21 unchanged, no pixel lost, sequence completes with 6 windows.
- Two frames back-to-back, second frame pixel = 100+10*r+c → 12 windows total. Second frame's first center is 111 (no data from frame 1 leaks into it); `m_last` asserted twice.
- `s_sof` asserted at frame pixel (1,3) with data 0 → treated as (0,0); the next window appears only after two further full rows plus 3 pixels.
- `rst_n` pulsed low while `m_valid`=1 at center 12 → `m_valid` drops immediately; subsequent full frame yields exactly 6 correct windows.
- With `LAP_WIN_CORNERS_EN`, ramp frame → first window `m_tl`=0, `m_tr`=2, `m_bl`=20, `m_br`=22.
